// File: rtl/systolic_array.sv
// Weight-stationary ROWS x COLS MAC array: shadow/active weights with a skewed swap
// wavefront, A flowing right, partial sums flowing down, C leaving the bottom row.
module systolic_array #(
    parameter int ROWS        = 2,
    parameter int COLS        = 2,
    parameter int WIDTH       = 4,
    parameter int ACC_WIDTH   = 9,
    parameter int MUL_LATENCY = 0,
    parameter int ADD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      b_load,
    input  logic                      b_update,
    input  logic [ROWS*WIDTH-1:0]     a_row_flat,
    input  logic [COLS*WIDTH-1:0]     b_col_flat,
    output logic [COLS*ACC_WIDTH-1:0] c_col_flat,
    output logic                      b_update_done
);

    // Done drops for the token's first COLS-1 positions, or only the pulse cycle when COLS=1.
    localparam int DONE_W = (COLS > 1) ? COLS - 1 : 1;

    logic [COLS-1:0]      col_swap;
    logic [WIDTH-1:0]     a_in     [ROWS][COLS];
    logic [WIDTH-1:0]     sw       [ROWS][COLS];
    logic [ACC_WIDTH-1:0] psum_out [ROWS][COLS];
    logic                 done_q;
    logic                 done_d;

    assign col_swap[0] = b_update;

    genvar gr, gc;
    generate
        for (gc = 1; gc < COLS; gc++) begin : g_tok
            logic tok_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) tok_q <= 1'b0;
                else        tok_q <= col_swap[gc-1];
            end
            assign col_swap[gc] = tok_q;
        end
    endgenerate

    assign done_d = ~(|col_swap[DONE_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b1;
        else        done_q <= done_d;
    end

    assign b_update_done = done_q;

    generate
        for (gr = 0; gr < ROWS; gr++) begin : g_row
            for (gc = 0; gc < COLS; gc++) begin : g_col
                logic [WIDTH-1:0]     sw_in;
                logic [WIDTH-1:0]     sw_q;
                logic [WIDTH-1:0]     aw_q;
                logic [2*WIDTH-1:0]   prod;
                logic [ACC_WIDTH-1:0] prod_ext;
                logic [ACC_WIDTH-1:0] prod_d;
                logic [ACC_WIDTH-1:0] psum_in;
                logic [ACC_WIDTH-1:0] sum_d;
                logic [ACC_WIDTH-1:0] add_q [ADD_LATENCY];

                if (gr == 0) begin : g_sw_top
                    assign sw_in = b_col_flat[gc*WIDTH +: WIDTH];
                end else begin : g_sw_chain
                    assign sw_in = sw[gr-1][gc];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)      sw_q <= '0;
                    else if (b_load) sw_q <= sw_in;
                end
                assign sw[gr][gc] = sw_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)            aw_q <= '0;
                    else if (col_swap[gc]) aw_q <= sw[gr][gc];
                end

                if (gc == 0) begin : g_a_edge
                    assign a_in[gr][gc] = a_row_flat[gr*WIDTH +: WIDTH];
                end else begin : g_a_reg
                    logic [WIDTH-1:0] a_q;
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) a_q <= '0;
                        else        a_q <= a_in[gr][gc-1];
                    end
                    assign a_in[gr][gc] = a_q;
                end

                assign prod     = {{WIDTH{1'b0}}, a_in[gr][gc]} * {{WIDTH{1'b0}}, aw_q};
                assign prod_ext = ACC_WIDTH'(prod);

                if (MUL_LATENCY == 0) begin : g_mul_comb
                    assign prod_d = prod_ext;
                end else begin : g_mul_pipe
                    logic [ACC_WIDTH-1:0] mul_q [MUL_LATENCY];
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            for (int k = 0; k < MUL_LATENCY; k++) mul_q[k] <= '0;
                        end else begin
                            mul_q[0] <= prod_ext;
                            for (int k = 1; k < MUL_LATENCY; k++) mul_q[k] <= mul_q[k-1];
                        end
                    end
                    assign prod_d = mul_q[MUL_LATENCY-1];
                end

                if (gr == 0) begin : g_psum_top
                    assign psum_in = '0;
                end else begin : g_psum_chain
                    assign psum_in = psum_out[gr-1][gc];
                end

                // Row r-1's sum emerges exactly when row r's delayed product does.
                assign sum_d = psum_in + prod_d;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int k = 0; k < ADD_LATENCY; k++) add_q[k] <= '0;
                    end else begin
                        add_q[0] <= sum_d;
                        for (int k = 1; k < ADD_LATENCY; k++) add_q[k] <= add_q[k-1];
                    end
                end
                assign psum_out[gr][gc] = add_q[ADD_LATENCY-1];
            end
        end

        for (gc = 0; gc < COLS; gc++) begin : g_out
            assign c_col_flat[gc*ACC_WIDTH +: ACC_WIDTH] = psum_out[ROWS-1][gc];
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: timeline of loads/updates/A streams per job, expected C
// computed as plain matrix products placed at their due cycles.
module tb_systolic_array;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // d0: default 2x2, d1: 2x2 with 8-bit accumulator, d2: 3x3 with MUL=2, ADD=2
    logic [7:0]  a0, b0;  logic [17:0] c0; logic bl0, up0, dn0;
    logic [7:0]  a1, b1;  logic [15:0] c1; logic bl1, up1, dn1;
    logic [11:0] a2, b2;  logic [26:0] c2; logic bl2, up2, dn2;

    systolic_array u_d0 (
        .clk(clk), .rst_n(rst_n), .b_load(bl0), .b_update(up0),
        .a_row_flat(a0), .b_col_flat(b0), .c_col_flat(c0), .b_update_done(dn0)
    );

    systolic_array #(.ACC_WIDTH(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .b_load(bl1), .b_update(up1),
        .a_row_flat(a1), .b_col_flat(b1), .c_col_flat(c1), .b_update_done(dn1)
    );

    systolic_array #(.ROWS(3), .COLS(3), .MUL_LATENCY(2), .ADD_LATENCY(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .b_load(bl2), .b_update(up2),
        .a_row_flat(a2), .b_col_flat(b2), .c_col_flat(c2), .b_update_done(dn2)
    );

    int passed = 0;
    int total  = 0;

    int tl_a [48][3];
    int tl_b [48][3];
    int tl_c [48][3];
    bit tl_bload [48];
    bit tl_upd [48];
    int ja [8][3];
    int jb [3][3];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tl_clear();
        for (int n = 0; n < 48; n++) begin
            tl_bload[n] = 1'b0;
            tl_upd[n]   = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tl_a[n][k] = 0; tl_b[n][k] = 0; tl_c[n][k] = 0;
            end
        end
    endtask

    // Schedule one job with its update at cycle t_up; expected C = A x B mod 2^aw.
    task automatic add_job(int nr, int nc, int al, int ml, int aw, int t_up, int m, bit load);
        int d;
        int s;
        d = nr * al + ml;
        if (load) begin
            for (int k = 0; k < nr; k++) begin
                tl_bload[t_up - nr + k] = 1'b1;
                for (int c = 0; c < nc; c++) tl_b[t_up - nr + k][c] = jb[nr-1-k][c];
            end
        end
        tl_upd[t_up] = 1'b1;
        for (int t = 0; t < m; t++)
            for (int r = 0; r < nr; r++)
                tl_a[t_up + 1 + t + r*al][r] = ja[t][r];
        for (int t = 0; t < m; t++) begin
            for (int c = 0; c < nc; c++) begin
                s = 0;
                for (int r = 0; r < nr; r++) s += ja[t][r] * (load ? jb[r][c] : 0);
                tl_c[t_up + 1 + t + c + d][c] = s % (1 << aw);
            end
        end
    endtask

    task automatic idle();
        a0 = '0; b0 = '0; bl0 = 1'b0; up0 = 1'b0;
        a1 = '0; b1 = '0; bl1 = 1'b0; up1 = 1'b0;
        a2 = '0; b2 = '0; bl2 = 1'b0; up2 = 1'b0;
    endtask

    task automatic drive(int id, int n);
        case (id)
            0: begin
                bl0 = tl_bload[n]; up0 = tl_upd[n];
                for (int k = 0; k < 2; k++) begin
                    a0[k*4 +: 4] = 4'(tl_a[n][k]); b0[k*4 +: 4] = 4'(tl_b[n][k]);
                end
            end
            1: begin
                bl1 = tl_bload[n]; up1 = tl_upd[n];
                for (int k = 0; k < 2; k++) begin
                    a1[k*4 +: 4] = 4'(tl_a[n][k]); b1[k*4 +: 4] = 4'(tl_b[n][k]);
                end
            end
            default: begin
                bl2 = tl_bload[n]; up2 = tl_upd[n];
                for (int k = 0; k < 3; k++) begin
                    a2[k*4 +: 4] = 4'(tl_a[n][k]); b2[k*4 +: 4] = 4'(tl_b[n][k]);
                end
            end
        endcase
    endtask

    function automatic logic [31:0] get_c(int id, int c);
        case (id)
            0:       return 32'(c0[c*9 +: 9]);
            1:       return 32'(c1[c*8 +: 8]);
            default: return 32'(c2[c*9 +: 9]);
        endcase
    endfunction

    function automatic logic [31:0] get_done(int id);
        case (id)
            0:       return 32'(dn0);
            1:       return 32'(dn1);
            default: return 32'(dn2);
        endcase
    endfunction

    task automatic run(int id, int nc, int len, string name);
        logic [31:0] exp_done;
        int w;
        w = (nc > 1) ? nc - 1 : 1;
        for (int n = 0; n < len; n++) begin
            @(posedge clk); #1;
            drive(id, n);
            @(negedge clk);
            for (int c = 0; c < nc; c++)
                check($sformatf("%s_c%0d_cyc%0d", name, c, n), get_c(id, c), 32'(tl_c[n][c]));
            exp_done = 32'd1;
            for (int m = n - w; m < n; m++)
                if (m >= 0 && tl_upd[m]) exp_done = 32'd0;
            check($sformatf("%s_done_cyc%0d", name, n), get_done(id), exp_done);
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rand_mats(int nr, int nc, int m);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) jb[r][c] = int'($urandom_range(0, 15));
        for (int t = 0; t < m; t++)
            for (int r = 0; r < nr; r++) ja[t][r] = int'($urandom_range(0, 15));
    endtask

    task automatic check_all_reset(string name);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("%s_d0_c%0d", name, c), get_c(0, c), 32'd0);
            check($sformatf("%s_d1_c%0d", name, c), get_c(1, c), 32'd0);
        end
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_d2_c%0d", name, c), get_c(2, c), 32'd0);
        check({name, "_d0_done"}, get_done(0), 32'd1);
        check({name, "_d1_done"}, get_done(1), 32'd1);
        check({name, "_d2_done"}, get_done(2), 32'd1);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_reset("reset");
        rst_n = 1'b1;

        // Basic product with the documented matrices
        tl_clear();
        jb[0][0] = 5; jb[0][1] = 6; jb[1][0] = 7; jb[1][1] = 8;
        ja[0][0] = 1; ja[0][1] = 2; ja[1][0] = 3; ja[1][1] = 4;
        add_job(2, 2, 1, 0, 9, 3, 2, 1'b1);
        run(0, 2, 12, "basic");

        // Back-to-back: job 2's update the cycle after job 1's last A
        tl_clear();
        ja[0][0] = 1; ja[0][1] = 0; ja[1][0] = 0; ja[1][1] = 1;
        add_job(2, 2, 1, 0, 9, 3, 2, 1'b1);
        jb[0][0] = 1; jb[0][1] = 0; jb[1][0] = 0; jb[1][1] = 1;
        ja[0][0] = 1; ja[0][1] = 2; ja[1][0] = 3; ja[1][1] = 4;
        add_job(2, 2, 1, 0, 9, 7, 2, 1'b1);
        run(0, 2, 16, "b2b");

        // Random jobs on the default array
        for (int j = 0; j < 2; j++) begin
            tl_clear();
            rand_mats(2, 2, 4);
            add_job(2, 2, 1, 0, 9, 3, 4, 1'b1);
            run(0, 2, 14, $sformatf("rand%0d", j));
        end

        // Wrap with an 8-bit accumulator
        tl_clear();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                jb[r][c] = 15; ja[r][c] = 15;
            end
        add_job(2, 2, 1, 0, 8, 3, 2, 1'b1);
        run(1, 2, 12, "wrap");

        // Latency sweep on the 3x3 pipelined array
        for (int j = 0; j < 2; j++) begin
            tl_clear();
            rand_mats(3, 3, 3);
            add_job(3, 3, 2, 2, 9, 4, 3, 1'b1);
            run(2, 3, 22, $sformatf("lat%0d", j));
        end

        // Reset while partial sums are in flight
        tl_clear();
        rand_mats(2, 2, 2);
        jb[0][0] = 9;
        ja[0][0] = 7;
        add_job(2, 2, 1, 0, 9, 3, 2, 1'b1);
        run(0, 2, 6, "prerst");
        rst_n = 1'b0;
        #1;
        check_all_reset("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_reset("postrst");

        // Swap without loading: weights must have been cleared
        tl_clear();
        rand_mats(2, 2, 2);
        ja[0][0] = 15;
        add_job(2, 2, 1, 0, 9, 1, 2, 1'b0);
        run(0, 2, 10, "stale");

        tl_clear();
        rand_mats(2, 2, 3);
        add_job(2, 2, 1, 0, 9, 3, 3, 1'b1);
        run(0, 2, 12, "fresh");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
